// File: rtl/rvc_dmem_resp_if.sv
// Request/response bus between the core's D_MEM port and the data-memory responder.
// A request transfers on the rising edge where req_valid && req_ready are both high;
// rsp_valid is a one-cycle strobe with no backpressure, and rsp_rd_data/rsp_err are meaningful only while it is high.
interface rvc_dmem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wr_en;
    logic [3:0]  req_byte_en;
    logic [31:0] req_wr_data;
    logic        req_sign_ext;
    logic        rsp_valid;
    logic [31:0] rsp_rd_data;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_wr_en, req_byte_en, req_wr_data, req_sign_ext,
        input  req_ready, rsp_valid, rsp_rd_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wr_en, req_byte_en, req_wr_data, req_sign_ext,
        output req_ready, rsp_valid, rsp_rd_data, rsp_err
    );
endinterface

// File: rtl/rvc_dmem_resp.sv
// Multi-cycle data-memory responder: byte-lane store merging, latency-delayed load data with lane extraction.
// Optional request checking (bad upper address bits, illegal byte enables) is enabled by RVC_DMEM_ERR_CHK_EN.
module rvc_dmem_resp #(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    rvc_dmem_resp_if.slave    bus,
    output logic [1:0]        state_dbg
);
    localparam int DEPTH = 1 << (ADDR_W - 2);
    localparam logic [3:0] LAST_CNT = 4'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state, next_state;
    logic [3:0]        cnt, next_cnt;
    logic              ready, accept;
    logic [ADDR_W-3:0] idx;
    logic [31:0]       rd_word;
    logic              acc_err;
    logic [31:0]       acc_data;
    logic [31:0]       pend_data;
    logic              pend_err;
    logic [31:0]       rsp_data_q;
    logic              rsp_err_q;
    logic [31:0]       mem [DEPTH];
    logic              unused_bits;

    function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [3:0] be,
                                                 input logic se);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'h00;
        h = 16'h0000;
        lane_extract = w;
        case (be)
            4'b0001: begin b = w[7:0];   lane_extract = {{24{se & b[7]}}, b}; end
            4'b0010: begin b = w[15:8];  lane_extract = {{24{se & b[7]}}, b}; end
            4'b0100: begin b = w[23:16]; lane_extract = {{24{se & b[7]}}, b}; end
            4'b1000: begin b = w[31:24]; lane_extract = {{24{se & b[7]}}, b}; end
            4'b0011: begin h = w[15:0];  lane_extract = {{16{se & h[15]}}, h}; end
            4'b1100: begin h = w[31:16]; lane_extract = {{16{se & h[15]}}, h}; end
            default: lane_extract = w;
        endcase
    endfunction

    assign idx         = bus.req_addr[ADDR_W-1:2];
    assign rd_word     = mem[idx];
    assign accept      = bus.req_valid && ready;
    assign unused_bits = ^{bus.req_addr[31:ADDR_W], bus.req_addr[1:0]};

`ifdef RVC_DMEM_ERR_CHK_EN
    assign acc_err = (bus.req_addr[31:ADDR_W] != '0) ||
                     !(bus.req_byte_en inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                               4'b0011, 4'b1100, 4'b1111});
`else
    assign acc_err = 1'b0;
`endif

    // Stores and errored requests answer with zero data.
    assign acc_data = (bus.req_wr_en || acc_err) ? 32'h0
                    : lane_extract(rd_word, bus.req_byte_en, bus.req_sign_ext);

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        ready      = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (bus.req_valid) begin
                    if (!bus.req_wr_en && RD_LAT > 1) begin
                        next_state = S_WAIT;
                        next_cnt   = 4'd1;
                    end else begin
                        next_state = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == LAST_CNT) begin
                    next_state = S_RESP;
                    next_cnt   = 4'd0;
                end else begin
                    next_cnt = cnt + 4'd1;
                end
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                next_state    = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            pend_data  <= 32'h0;
            pend_err   <= 1'b0;
            rsp_data_q <= 32'h0;
            rsp_err_q  <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (accept) begin
                pend_data <= acc_data;
                pend_err  <= acc_err;
            end
            // Response registers change only on entry to RESP so they hold outside the strobe.
            if (next_state == S_RESP) begin
                rsp_data_q <= (state == S_IDLE) ? acc_data : pend_data;
                rsp_err_q  <= (state == S_IDLE) ? acc_err  : pend_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept && bus.req_wr_en && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_byte_en[i]) begin
                    mem[idx][8*i +: 8] <= bus.req_wr_data[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready   = ready;
    assign bus.rsp_rd_data = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign state_dbg       = state;
endmodule

// File: tb/tb_rvc_dmem_resp.sv
// Randomized scoreboard bench for rvc_dmem_resp against a word-array reference model.
module tb_rvc_dmem_resp;
    localparam int ADDR_W = 12;
    localparam int RD_LAT = 4;
    localparam int NWORDS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] state_dbg;
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    logic [32:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [31:0] model_mem [1 << (ADDR_W - 2)];

    rvc_dmem_resp_if bus ();

    rvc_dmem_resp #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [3:0] be,
                                               input logic se);
        int k;
        logic [31:0] v;
        if (be == 4'd1 || be == 4'd2 || be == 4'd4 || be == 4'd8) begin
            k = (be == 4'd1) ? 0 : (be == 4'd2) ? 1 : (be == 4'd4) ? 2 : 3;
            v = (w >> (8 * k)) & 32'hFF;
            if (se && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (be == 4'd3 || be == 4'd12) begin
            k = (be == 4'd3) ? 0 : 2;
            v = (w >> (8 * k)) & 32'hFFFF;
            if (se && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic model_err(input logic [31:0] addr, input logic [3:0] be);
`ifdef RVC_DMEM_ERR_CHK_EN
        return ((addr >> ADDR_W) != 0) ||
               !(be inside {4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd12, 4'd15});
`else
        return 1'b0;
`endif
    endfunction

    // Called right after the accepting edge: applies the request to the model and queues the response.
    task automatic model_accept(input logic [31:0] addr, input logic wr, input logic [3:0] be,
                                input logic [31:0] wdata, input logic se, input int acc_cyc);
        int idx;
        logic err;
        logic [31:0] d;
        idx = int'((addr % (1 << ADDR_W)) / 4);
        err = model_err(addr, be);
        d = 32'h0;
        if (!err) begin
            if (wr) begin
                for (int k = 0; k < 4; k++)
                    if (be[k]) model_mem[idx][8*k +: 8] = wdata[8*k +: 8];
            end else begin
                d = model_load(model_mem[idx], be, se);
            end
        end
        exp_q.push_back({err, d});
        exp_cyc_q.push_back(acc_cyc + (wr ? 1 : RD_LAT));
    endtask

    // Entered and left just after a rising edge; leaves req_valid high when hold is set.
    task automatic send(input logic [31:0] addr, input logic wr, input logic [3:0] be,
                        input logic [31:0] wdata, input logic se, input bit hold);
        int t;
        int acc_cyc;
        bus.req_addr     = addr;
        bus.req_wr_en    = wr;
        bus.req_byte_en  = be;
        bus.req_wr_data  = wdata;
        bus.req_sign_ext = se;
        bus.req_valid    = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus.req_ready) begin
            t++;
            if (t > 50) begin
                n_tests++;
                n_fail++;
                $display("FAIL accept_timeout: ready never rose, got 0 expected 1");
                bus.req_valid = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
            @(negedge clk);
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        model_accept(addr, wr, be, wdata, se, acc_cyc);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        int c;
        if (!rst) begin
            check("req_ready", 64'(bus.req_ready), 64'(exp_q.size() == 0));
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    check("rsp_cycle", 64'(cyc), 64'(c));
                    check("rsp_rd_data", 64'(bus.rsp_rd_data), 64'(e[31:0]));
                    check("rsp_err", 64'(bus.rsp_err), 64'(e[32]));
                end
            end
        end
    end

    initial begin
        logic [31:0] addr;
        logic [31:0] upper;
        logic [3:0]  be;
        logic [3:0]  legal_be [7];
        int t;
        legal_be = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd12, 4'd15};
        bus.req_valid = 1'b0;
        bus.req_addr = 32'h0;
        bus.req_wr_en = 1'b0;
        bus.req_byte_en = 4'h0;
        bus.req_wr_data = 32'h0;
        bus.req_sign_ext = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_ready", 64'(bus.req_ready), 64'd1);
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset_rsp_data", 64'(bus.rsp_rd_data), 64'd0);
        check("reset_rsp_err", 64'(bus.rsp_err), 64'd0);

        for (int i = 0; i < NWORDS; i++)
            send(32'(i * 4), 1'b1, 4'hF, $urandom, 1'b0, 1'b1);

        send(32'h010, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        send(32'h010, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        send(32'h010, 1'b1, 4'h4, 32'h00AA_0000, 1'b0, 1'b0);
        send(32'h010, 1'b0, 4'h4, 32'h0, 1'b1, 1'b0);
        send(32'h010, 1'b0, 4'h4, 32'h0, 1'b0, 1'b0);
        send(32'h010, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
        send(32'h014, 1'b1, 4'hF, 32'h8001_1234, 1'b0, 1'b0);
        send(32'h014, 1'b0, 4'hC, 32'h0, 1'b1, 1'b0);
        send(32'h014, 1'b0, 4'hC, 32'h0, 1'b0, 1'b0);
        send(32'h016, 1'b0, 4'h3, 32'h0, 1'b1, 1'b1);
`ifdef RVC_DMEM_ERR_CHK_EN
        send(32'h0000_2000, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        send(32'h010, 1'b1, 4'h6, 32'h1234_5678, 1'b0, 1'b0);
        send(32'h010, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
`else
        send(32'h0000_2010, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        send(32'h010, 1'b1, 4'h6, 32'h1234_5678, 1'b0, 1'b0);
        send(32'h010, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
`endif

        // Reset during WAIT drops the load; a store presented under reset must be ignored.
        send(32'h020, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        exp_cyc_q.delete();
        bus.req_addr = 32'h024;
        bus.req_wr_en = 1'b1;
        bus.req_byte_en = 4'hF;
        bus.req_wr_data = ~model_mem[9];
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        check("post_reset_ready", 64'(bus.req_ready), 64'd1);
        check("post_reset_rsp_data", 64'(bus.rsp_rd_data), 64'd0);
        send(32'h024, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        send(32'h020, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            upper = 32'h0;
`ifdef RVC_DMEM_ERR_CHK_EN
            if ($urandom_range(0, 7) == 0) upper = $urandom_range(1, 32'hF_FFFF);
`else
            upper = $urandom_range(0, 32'hF_FFFF);
`endif
            addr = (upper << ADDR_W) | 32'($urandom_range(0, NWORDS - 1) * 4)
                 | 32'($urandom_range(0, 3));
            be = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                             : legal_be[$urandom_range(0, 6)];
            send(addr, 1'($urandom_range(0, 1)), be, $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        bus.req_valid = 1'b0;

        t = 0;
        while (exp_q.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rvc_dmem_resp.md
Name: rvc_dmem_resp

Overview:
- Data-memory responder at the far end of the core's D_MEM port.
- Accepts one load/store request at a time over a valid/ready handshake and performs byte-lane write merging into a word array.
- Returns load data after a parameterised latency, with byte/halfword lane extraction and sign or zero extension.
- Used as the multi-cycle D_MEM target behind the core in place of the single-cycle memory wrapper.

Parameters:
- ADDR_W, 12: byte-address width decoded; array depth = 2^(ADDR_W-2) words.
- RD_LAT, 2: read latency in cycles from accept to RspValid; legal range 1..8.

Ports:
- Clock, input, 1: single clock, all state on rising edge.
- Rst, input, 1: synchronous, active-high reset.
- ReqValid, input, 1: request present.
- ReqReady, output, 1: responder can accept.
- ReqAddr, input, 32: byte address (core AluOut).
- ReqWrEn, input, 1: 1 = store, 0 = load.
- ReqByteEn, input, 4: lane enables; bit i selects bits [8i+7:8i].
- ReqWrData, input, 32: store data, already lane-aligned.
- ReqSignExt, input, 1: 1 = sign-extend a sub-word load, 0 = zero-extend.
- RspValid, output, 1: one-cycle response strobe.
- RspRdData, output, 32: load result, right-justified and extended.
- RspErr, output, 1: request rejected; qualified by RspValid.

Behaviour:
- Reset values: state IDLE; ReqReady=1; RspValid=0; RspRdData=0; RspErr=0; latency counter=0. Array contents are not reset.
- Requests presented while Rst=1 are ignored.
- States:
  - IDLE: ReqReady=1. Accept occurs on ReqValid&&ReqReady. On accept, capture address word index, ByteEn, SignExt and WrEn. Go to WAIT if load and RD_LAT>1, otherwise go to RESP.
  - WAIT: ReqReady=0. Counter runs from 1; go to RESP when counter==RD_LAT-1.
  - RESP: RspValid=1, ReqReady=0 for exactly one cycle, then IDLE.
- Latency: a store's RspValid is asserted in cycle accept+1. A load's RspValid is asserted in cycle accept+RD_LAT. A new accept is possible one cycle after RESP. Only one request is outstanding; there is no response backpressure.
- Store: enabled lanes of ReqWrData are written at the accept edge; disabled lanes are untouched. A store response carries RspRdData=0.
- Load: the word is read at accept. Lane extraction by ByteEn:
  - 0001/0010/0100/1000: byte moved to [7:0], bits [31:8] filled from bit 7 if SignExt, else 0.
  - 0011/1100: halfword moved to [15:0], extended from bit 15 likewise.
  - 1111: full word; SignExt ignored.
- Errors: see Optional Feature. An errored request writes nothing and returns RspRdData=0, RspErr=1, with the same latency as a non-errored request.
- Address index uses ReqAddr[ADDR_W-1:2]; ReqAddr[1:0] is ignored (lane choice comes only from ByteEn).
- Rst asserted mid-WAIT or mid-RESP: the next cycle is IDLE, RspValid=0, and the pending response is dropped. A store is already committed at accept and is not undone.
- RspRdData and RspErr hold their last value outside RspValid; they are cleared only by reset.

Optional Feature:
- Macro RVC_DMEM_ERR_CHK_EN.
- Defined:
  - RspErr=1 if ReqAddr[31:ADDR_W]!=0.
  - RspErr=1 if ReqByteEn is not one of {0001,0010,0100,1000,0011,1100,1111}; 0000 is illegal.
- Undefined:
  - No checks; RspErr is tied to 0.
  - Upper address bits are ignored, so addresses alias/wrap.
  - An illegal ByteEn on a load is treated as 1111. An illegal ByteEn on a store writes exactly the enabled lanes.

Test Plan:
- Store 0xDEADBEEF to 0x010 with ByteEn 1111, then load 0x010 with ByteEn 1111 -> store RspValid at accept+1 with RspRdData=0; load RspValid exactly RD_LAT cycles after accept with 0xDEADBEEF.
- After the previous store, store 0x00AA0000 with ByteEn 0100, then load ByteEn 0100 with SignExt=1 -> 0xFFFFFFAA; with SignExt=0 -> 0x000000AA; full word reads 0xDEAABEEF.
- Load ByteEn 1100 from a word holding 0x8001_1234 with SignExt=1 -> 0xFFFF8001; with SignExt=0 -> 0x00008001.
- With RVC_DMEM_ERR_CHK_EN defined: load 0x0000_2000 (ADDR_W=12) -> RspErr=1, RspRdData=0. Store with ByteEn 0110 -> RspErr=1 and a following read shows memory unchanged.
- With RD_LAT=4: accept a load, assert Rst for one cycle at accept+2 -> no RspValid ever for that load; ReqReady=1 the cycle after reset; a new load then completes normally.
- Hold ReqValid high with alternating store/load -> ReqReady deasserted from accept until the cycle after RESP; no request accepted twice or dropped; responses in order.
